cntx_axis_packer: RTL and testbench

Stream re-assembler at the output end of the stereo context path. Accepts per-beat result pixels plus per-lane pixel-valid flags and the tvalid/tlast/tuser/tready sideband produced by the context generator and its downstream processing. Masks border lanes, packs the lanes into an AXI4-Stream video beat and drives the video output through a 2-entry skid buffer. Also checks line length and frame height against parameters and keeps sticky error flags.

---
 rtl/cntx_pkg.sv | 53 +++++
 rtl/axis_skid_buffer.sv | 86 ++++++++
 rtl/cntx_axis_packer.sv | 208 ++++++++++++++++++++
 tb/tb_cntx_axis_packer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cntx_pkg.sv
// ---------------------------------------------------------------------------
// cntx_pkg
// Shared definitions for the context-path output packer.
//   cntx_state_e : frame tracking state (SYNC until the first start-of-frame
//                  beat, then ACTIVE for the rest of the stream)
//   GROUPS       : beats per line for the default 3840-pixel, 4-lane geometry
//   pack_lanes() : border-masks the lanes and packs them with lane 0 in the
//                  most significant pixel slot of the result
// ---------------------------------------------------------------------------
package cntx_pkg;

   typedef enum logic [0:0] {
      ST_SYNC   = 1'b0,
      ST_ACTIVE = 1'b1
   } cntx_state_e;

   localparam int DEF_WIDTH             = 3840;
   localparam int DEF_SAMPLES_PER_CLOCK = 4;
   localparam int GROUPS                = DEF_WIDTH / DEF_SAMPLES_PER_CLOCK;

   // Upper bounds for the lane geometry handled by pack_lanes(). The caller
   // zero-fills unused lanes/bits and truncates the result to its tdata width.
   localparam int MAX_LANES = 16;
   localparam int MAX_BPP   = 16;
   localparam int PACK_W    = MAX_LANES * MAX_BPP;

   typedef logic [MAX_LANES-1:0][MAX_BPP-1:0] lane_vec_t;
   typedef logic [PACK_W-1:0]                 pack_vec_t;

   // Lane j (j < spc) lands at bits [bpp*(spc-j)-1 -: bpp] of the result;
   // a lane whose valid flag is low carries the border value instead.
   function automatic pack_vec_t pack_lanes(
      input lane_vec_t              pixels,
      input logic [MAX_LANES-1:0]   valid,
      input logic [MAX_BPP-1:0]     border,
      input int                     spc,
      input int                     bpp
   );
      pack_vec_t            r;
      logic [MAX_BPP-1:0]   lane;
      r = '0;
      for (int j = 0; j < MAX_LANES; j++) begin
         lane = valid[j] ? pixels[j] : border;
         for (int b = 0; b < MAX_BPP; b++) begin
            if (j < spc && b < bpp) begin
               r[bpp*(spc-1-j)+b] = lane[b];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry output stage: a main register that drives the stream and one
// skid register that absorbs a single beat while the main register is
// stalled. Beat order is preserved; nothing is dropped or duplicated.
//
// Handshake: a beat moves across an interface on a clock edge where both
// valid and ready are high. A source holding valid keeps its data stable
// until that edge. s_ready_o is a register (low in reset, high when the
// skid entry is empty), so it never depends combinationally on m_ready_i.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   s_data_i/_valid_i  upstream beat, s_ready_o = skid entry free
//   m_data_o/_valid_o  downstream beat (main register), m_ready_i
// ---------------------------------------------------------------------------
module axis_skid_buffer #(
   parameter int DATA_W = 34
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   output logic [DATA_W-1:0] m_data_o,
   output logic              m_valid_o,
   input  logic              m_ready_i
);

   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic              ready_q, ready_d;
   logic              in_fire;

   always_comb begin
      main_data_d  = main_data_q;
      main_valid_d = main_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      in_fire      = s_valid_i & ready_q;

      if (!main_valid_q || m_ready_i) begin
         // Main register is empty or handing off its beat this cycle.
         if (skid_valid_q) begin
            // The held beat is older than anything upstream; it goes first.
            main_data_d  = skid_data_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = in_fire;
            if (in_fire) begin
               main_data_d = s_data_i;
            end
         end
      end else if (in_fire) begin
         // Main is stalled: park the incoming beat in the skid entry.
         skid_data_d  = s_data_i;
         skid_valid_d = 1'b1;
      end

      ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_data_q  <= '0;
         main_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b0;
      end else begin
         main_data_q  <= main_data_d;
         main_valid_q <= main_valid_d;
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
      end
   end

   assign s_ready_o = ready_q;
   assign m_data_o  = main_data_q;
   assign m_valid_o = main_valid_q;

endmodule

// File: rtl/cntx_axis_packer.sv
// ---------------------------------------------------------------------------
// cntx_axis_packer
// Re-assembles the context path output into an AXI4-Stream video beat:
// border lanes are replaced by BORDER_VALUE, lanes are packed with lane 0 in
// the top pixel slot, and the beat plus its tuser/tlast leaves through a
// two-entry skid buffer. Line length and frame height are tracked once the
// first start-of-frame beat has been seen and mismatches raise sticky flags.
//
// Ports
//   s_axis_aclk, s_axis_aresetn     clock, asynchronous active-low reset
//   in_pixels, in_pixel_valid       per-lane result pixels and valid flags
//   in_tvalid/tlast/tuser, in_tready input beat handshake and qualifiers
//   VIDEO_OUT_tdata/tvalid/tlast/tuser, VIDEO_OUT_tready  video output
//   err_clear                        synchronous clear of the error flags
//   line_len_err, frame_height_err   sticky error flags
//   dbg_state                        current frame tracking state
// ---------------------------------------------------------------------------
module cntx_axis_packer
   import cntx_pkg::*;
#(
   parameter int                        SAMPLES_PER_CLOCK = 4,
   parameter int                        BITS_PER_PIXEL    = 8,
   parameter int                        TDATA_WIDTH       = SAMPLES_PER_CLOCK * BITS_PER_PIXEL,
   parameter int                        N_CNTX            = 4,
   parameter int                        WIDTH             = 3840,
   parameter int                        HEIGHT            = 2160,
   parameter logic [BITS_PER_PIXEL-1:0] BORDER_VALUE      = '0,
   parameter int                        W_POSITION_WIDTH  = 10,
   parameter int                        H_POSITION_WIDTH  = 12
) (
   input  logic                                  s_axis_aclk,
   input  logic                                  s_axis_aresetn,
   input  logic [N_CNTX-1:0][BITS_PER_PIXEL-1:0] in_pixels,
   input  logic [N_CNTX-1:0]                     in_pixel_valid,
   input  logic                                  in_tvalid,
   input  logic                                  in_tlast,
   input  logic                                  in_tuser,
   output logic                                  in_tready,
   output logic [TDATA_WIDTH-1:0]                VIDEO_OUT_tdata,
   output logic                                  VIDEO_OUT_tvalid,
   output logic                                  VIDEO_OUT_tlast,
   output logic                                  VIDEO_OUT_tuser,
   input  logic                                  VIDEO_OUT_tready,
   input  logic                                  err_clear,
   output logic                                  line_len_err,
   output logic                                  frame_height_err,
   output cntx_state_e                           dbg_state
);

   localparam int SKID_W      = TDATA_WIDTH + 2;
   localparam int LINE_GROUPS = WIDTH / SAMPLES_PER_CLOCK;
   localparam logic [W_POSITION_WIDTH-1:0] LAST_X      = W_POSITION_WIDTH'(LINE_GROUPS - 1);
   localparam logic [H_POSITION_WIDTH-1:0] FRAME_LINES = H_POSITION_WIDTH'(HEIGHT);

   // ---------------- lane packing ----------------
   lane_vec_t              pix_wide;
   logic [MAX_LANES-1:0]   vld_wide;
   logic [TDATA_WIDTH-1:0] beat_tdata;

   // Only the first SAMPLES_PER_CLOCK lanes are packed; extra context lanes
   // are ignored.
   always_comb begin
      pix_wide = '0;
      vld_wide = '0;
      for (int j = 0; j < SAMPLES_PER_CLOCK; j++) begin
         pix_wide[j][BITS_PER_PIXEL-1:0] = in_pixels[j];
         vld_wide[j]                     = in_pixel_valid[j];
      end
   end

   assign beat_tdata = TDATA_WIDTH'(pack_lanes(pix_wide, vld_wide, MAX_BPP'(BORDER_VALUE),
                                                SAMPLES_PER_CLOCK, BITS_PER_PIXEL));

   // ---------------- output stage ----------------
   logic [SKID_W-1:0] skid_in, skid_out;
   logic              in_fire;

   assign skid_in = {in_tuser, in_tlast, beat_tdata};
   assign in_fire = in_tvalid & in_tready;

   axis_skid_buffer #(
      .DATA_W (SKID_W)
   ) u_skid (
      .clk_i     (s_axis_aclk),
      .rst_ni    (s_axis_aresetn),
      .s_data_i  (skid_in),
      .s_valid_i (in_tvalid),
      .s_ready_o (in_tready),
      .m_data_o  (skid_out),
      .m_valid_o (VIDEO_OUT_tvalid),
      .m_ready_i (VIDEO_OUT_tready)
   );

   assign VIDEO_OUT_tdata = skid_out[TDATA_WIDTH-1:0];
   assign VIDEO_OUT_tlast = skid_out[TDATA_WIDTH];
   assign VIDEO_OUT_tuser = skid_out[TDATA_WIDTH+1];

   // ---------------- frame FSM ----------------
   cntx_state_e state_q, state_d;
   logic        count_en;
   logic        height_chk;

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         state_q <= ST_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == ST_SYNC && in_fire && in_tuser) begin
         state_d = ST_ACTIVE;
      end
   end

   // The start-of-frame beat that leaves SYNC is already counted as the
   // first beat of line 0, but there is no previous frame to check.
   always_comb begin
      count_en   = 1'b0;
      height_chk = 1'b0;
      case (state_q)
         ST_SYNC: begin
            count_en = in_fire & in_tuser;
         end
         ST_ACTIVE: begin
            count_en   = in_fire;
            height_chk = in_fire & in_tuser;
         end
         default: begin
            count_en   = 1'b0;
            height_chk = 1'b0;
         end
      endcase
   end

   assign dbg_state = state_q;

   // ---------------- position counters ----------------
   logic [W_POSITION_WIDTH-1:0] pos_x_q, pos_x_d, cur_x;
   logic [H_POSITION_WIDTH-1:0] pos_y_q, pos_y_d, base_y;
   logic                        len_set;
   logic                        height_set;

   always_comb begin
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      len_set    = 1'b0;
      height_set = 1'b0;
      // A tuser beat always sits at position 0 of line 0.
      cur_x      = in_tuser ? '0 : pos_x_q;
      base_y     = in_tuser ? '0 : pos_y_q;

      if (count_en) begin
         if (in_tlast) begin
            len_set = (cur_x != LAST_X);
            pos_x_d = '0;
            pos_y_d = base_y + 1'b1;
         end else begin
            pos_y_d = base_y;
            if (cur_x == LAST_X) begin
               // Line overran: hold at the last slot until tlast shows up.
               len_set = 1'b1;
               pos_x_d = LAST_X;
            end else begin
               pos_x_d = cur_x + 1'b1;
            end
         end
      end

      height_set = height_chk & (pos_y_q != FRAME_LINES);
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         pos_x_q <= '0;
         pos_y_q <= '0;
      end else begin
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
      end
   end

   // ---------------- sticky error flags ----------------
   logic line_len_err_q, line_len_err_d;
   logic frame_height_err_q, frame_height_err_d;

   // A set event in the same cycle as err_clear wins.
   always_comb begin
      line_len_err_d     = len_set    ? 1'b1 : (err_clear ? 1'b0 : line_len_err_q);
      frame_height_err_d = height_set ? 1'b1 : (err_clear ? 1'b0 : frame_height_err_q);
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         line_len_err_q     <= 1'b0;
         frame_height_err_q <= 1'b0;
      end else begin
         line_len_err_q     <= line_len_err_d;
         frame_height_err_q <= frame_height_err_d;
      end
   end

   assign line_len_err     = line_len_err_q;
   assign frame_height_err = frame_height_err_q;

endmodule

// File: tb/tb_cntx_axis_packer.sv
// ---------------------------------------------------------------------------
// tb_cntx_axis_packer
// Directed bench for cntx_axis_packer configured as 16-pixel lines
// (4 beats) and 2-line frames. Inputs change 1 time unit after a rising
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_cntx_axis_packer;
   import cntx_pkg::*;

   localparam int SPC = 4;
   localparam int BPP = 8;
   localparam int NC  = 4;
   localparam int TW  = SPC * BPP;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NC-1:0][BPP-1:0] in_pixels;
   logic [NC-1:0]          in_pixel_valid;
   logic                   in_tvalid, in_tlast, in_tuser, in_tready;
   logic [TW-1:0]          vo_tdata;
   logic                   vo_tvalid, vo_tlast, vo_tuser, vo_tready;
   logic                   err_clear, line_len_err, frame_height_err;
   cntx_state_e            dbg_state;

   cntx_axis_packer #(
      .SAMPLES_PER_CLOCK (SPC),
      .BITS_PER_PIXEL    (BPP),
      .N_CNTX            (NC),
      .WIDTH             (16),
      .HEIGHT            (2),
      .BORDER_VALUE      (8'h00)
   ) dut (
      .s_axis_aclk      (clk),
      .s_axis_aresetn   (rst_n),
      .in_pixels        (in_pixels),
      .in_pixel_valid   (in_pixel_valid),
      .in_tvalid        (in_tvalid),
      .in_tlast         (in_tlast),
      .in_tuser         (in_tuser),
      .in_tready        (in_tready),
      .VIDEO_OUT_tdata  (vo_tdata),
      .VIDEO_OUT_tvalid (vo_tvalid),
      .VIDEO_OUT_tlast  (vo_tlast),
      .VIDEO_OUT_tuser  (vo_tuser),
      .VIDEO_OUT_tready (vo_tready),
      .err_clear        (err_clear),
      .line_len_err     (line_len_err),
      .frame_height_err (frame_height_err),
      .dbg_state        (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [TW+1:0] exp_q[$];
   int            checks   = 0;
   int            failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every output handshake must match the oldest expected beat.
   initial begin
      logic [TW+1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && vo_tvalid && vo_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL out_beat: got unexpected beat 0x%0h with none expected",
                        {vo_tuser, vo_tlast, vo_tdata});
            end else begin
               e = exp_q.pop_front();
               check("out_beat", 64'({vo_tuser, vo_tlast, vo_tdata}), 64'(e));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before the end of the test");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   // pix holds lane 0 in bits [31:24]; exp_data is the hand-computed tdata.
   task automatic send_beat(input logic [31:0] pix, input logic [3:0] vld,
                            input logic user, input logic last, input logic [31:0] exp_data);
      int waited = 0;
      for (int j = 0; j < NC; j++) in_pixels[j] = pix[31-8*j -: 8];
      in_pixel_valid = vld;
      in_tuser       = user;
      in_tlast       = last;
      in_tvalid      = 1'b1;
      @(negedge clk);
      while (!in_tready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!in_tready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_tready stayed 0 for %0d cycles, required 1", waited);
      end else begin
         exp_q.push_back({user, last, exp_data});
      end
      @(posedge clk);
      #1;
      in_tvalid = 1'b0;
      in_tuser  = 1'b0;
      in_tlast  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      idle(1);
      err_clear = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      in_pixels      = '0;
      in_pixel_valid = '0;
      in_tvalid      = 1'b0;
      in_tlast       = 1'b0;
      in_tuser       = 1'b0;
      vo_tready      = 1'b1;
      err_clear      = 1'b0;

      // Reset state
      #1;
      check("rst_tvalid", 64'(vo_tvalid), 64'(0));
      check("rst_tdata", 64'(vo_tdata), 64'(0));
      check("rst_tlast_tuser", 64'({vo_tlast, vo_tuser}), 64'(0));
      check("rst_in_tready", 64'(in_tready), 64'(0));
      check("rst_errors", 64'({line_len_err, frame_height_err}), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(ST_SYNC));
      idle(3);
      rst_n = 1'b1;
      idle(2);
      check("in_tready_after_rst", 64'(in_tready), 64'(1));

      // Line 1 of frame A: one-cycle latency for each beat
      send_beat(32'h01020304, 4'hF, 1'b1, 1'b0, 32'h01020304);
      check("lat_b0", 64'({vo_tvalid, vo_tdata}), 64'({1'b1, 32'h01020304}));
      check("state_active", 64'(dbg_state), 64'(ST_ACTIVE));
      send_beat(32'h05060708, 4'hF, 1'b0, 1'b0, 32'h05060708);
      check("lat_b1", 64'({vo_tvalid, vo_tdata}), 64'({1'b1, 32'h05060708}));
      send_beat(32'h090A0B0C, 4'hF, 1'b0, 1'b0, 32'h090A0B0C);
      check("lat_b2", 64'({vo_tvalid, vo_tdata}), 64'({1'b1, 32'h090A0B0C}));
      send_beat(32'h0D0E0F10, 4'hF, 1'b0, 1'b1, 32'h0D0E0F10);
      check("lat_b3", 64'({vo_tvalid, vo_tlast, vo_tdata}), 64'({2'b11, 32'h0D0E0F10}));
      idle(1);
      check("tvalid_drops", 64'(vo_tvalid), 64'(0));
      check("len_ok_line1", 64'(line_len_err), 64'(0));

      // Line 2: border masking
      send_beat(32'hAABBCCDD, 4'b0110, 1'b0, 1'b0, 32'h00BBCC00);
      check("border_0110", 64'(vo_tdata), 64'(32'h00BBCC00));
      send_beat(32'h31323334, 4'b1001, 1'b0, 1'b0, 32'h31000034);
      check("border_1001", 64'(vo_tdata), 64'(32'h31000034));
      send_beat(32'h21222324, 4'hF, 1'b0, 1'b0, 32'h21222324);
      send_beat(32'h292A2B2C, 4'hF, 1'b0, 1'b1, 32'h292A2B2C);
      idle(1);
      check("len_ok_line2", 64'(line_len_err), 64'(0));

      // Frame B starts after exactly 2 lines; downstream stalls for a while
      vo_tready = 1'b0;
      send_beat(32'h41424344, 4'hF, 1'b1, 1'b0, 32'h41424344);
      check("height_ok", 64'(frame_height_err), 64'(0));
      send_beat(32'h45464748, 4'hF, 1'b0, 1'b0, 32'h45464748);
      check("stall_in_tready", 64'(in_tready), 64'(0));
      check("stall_hold0", 64'({vo_tvalid, vo_tuser, vo_tdata}), 64'({2'b11, 32'h41424344}));
      idle(1);
      check("stall_hold1", 64'({vo_tvalid, vo_tuser, vo_tdata}), 64'({2'b11, 32'h41424344}));
      vo_tready = 1'b1;
      send_beat(32'h494A4B4C, 4'hF, 1'b0, 1'b0, 32'h494A4B4C);
      send_beat(32'h4D4E4F50, 4'hF, 1'b0, 1'b1, 32'h4D4E4F50);
      idle(2);

      // Short line: tlast on beat index 2
      send_beat(32'h51525354, 4'hF, 1'b0, 1'b0, 32'h51525354);
      send_beat(32'h55565758, 4'hF, 1'b0, 1'b0, 32'h55565758);
      check("len_before_short", 64'(line_len_err), 64'(0));
      send_beat(32'h595A5B5C, 4'hF, 1'b0, 1'b1, 32'h595A5B5C);
      check("len_short_set", 64'(line_len_err), 64'(1));
      pulse_clear();
      check("len_cleared", 64'(line_len_err), 64'(0));

      // Correct line: flag stays clear; frame B now holds 3 lines
      send_beat(32'h61626364, 4'hF, 1'b0, 1'b0, 32'h61626364);
      send_beat(32'h65666768, 4'hF, 1'b0, 1'b0, 32'h65666768);
      send_beat(32'h696A6B6C, 4'hF, 1'b0, 1'b0, 32'h696A6B6C);
      send_beat(32'h6D6E6F70, 4'hF, 1'b0, 1'b1, 32'h6D6E6F70);
      check("len_ok_line5", 64'(line_len_err), 64'(0));

      // Next frame start sees 3 lines instead of 2
      send_beat(32'h71727374, 4'hF, 1'b1, 1'b0, 32'h71727374);
      check("height_set", 64'(frame_height_err), 64'(1));
      check("len_ok_tuser", 64'(line_len_err), 64'(0));
      pulse_clear();
      check("height_cleared", 64'(frame_height_err), 64'(0));

      // Reset with a beat held on the output
      vo_tready = 1'b0;
      send_beat(32'h75767778, 4'hF, 1'b0, 1'b0, 32'h75767778);
      check("held_before_rst", 64'(vo_tvalid), 64'(1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_tvalid", 64'(vo_tvalid), 64'(0));
      check("async_rst_in_tready", 64'(in_tready), 64'(0));
      exp_q.delete();
      vo_tready = 1'b1;
      idle(2);
      rst_n = 1'b1;
      idle(2);
      check("state_sync_after_rst", 64'(dbg_state), 64'(ST_SYNC));

      // Partial line without tuser: forwarded, not counted
      send_beat(32'h81828384, 4'hF, 1'b0, 1'b0, 32'h81828384);
      send_beat(32'h85868788, 4'hF, 1'b0, 1'b1, 32'h85868788);
      send_beat(32'h898A8B8C, 4'hF, 1'b0, 1'b0, 32'h898A8B8C);
      idle(1);
      check("sync_no_errors", 64'({line_len_err, frame_height_err}), 64'(0));
      check("still_sync", 64'(dbg_state), 64'(ST_SYNC));

      // Drain
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
      check("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
